// File: rtl/npc_exec_ctrl.sv
// npc_exec_ctrl: multi-cycle FETCH/WAIT/EXEC sequencer for the NPC core.
// Owns the PC and the imem request handshake, latches the fetched word and
// executes ADDI / EBREAK against the register file. HALT is sticky until reset.
// Optional feature macro: ILLEGAL_TRAP_EN (undecoded words halt with code 2
// instead of retiring as a NOP).
module npc_exec_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h80000000,
  parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr,
  input  logic [31:0] rf_rdata,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_wen,
  output logic [31:0] pc,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  halt_code
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT} state_t;

  localparam logic [1:0] HC_EBREAK  = 2'd1;
  localparam logic [1:0] HC_ILLEGAL = 2'd2;
  localparam logic [1:0] HC_TIMEOUT = 2'd3;

  state_t      state, state_nxt;
  logic [31:0] ir, ir_nxt, pc_nxt;
  logic [7:0]  wait_cnt, cnt_nxt;
  logic [1:0]  code_nxt;

  logic        is_addi, is_ebreak;
  logic [4:0]  rd;
  logic [31:0] imm, addi_sum;

  assign is_addi   = (ir[6:0] == 7'b0010011) && (ir[14:12] == 3'b000);
  assign is_ebreak = (ir == 32'h00100073);
  assign rd        = ir[11:7];
  assign imm       = {{20{ir[31]}}, ir[31:20]};
  assign addi_sum  = rf_rdata + imm;

  // State, PC, instruction and wait-counter registers; reset abandons any fetch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      wait_cnt  <= '0;
      halt_code <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      ir        <= ir_nxt;
      wait_cnt  <= cnt_nxt;
      halt_code <= code_nxt;
    end
  end

  // Next-state decode and per-state output strobes
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ir_nxt    = ir;
    cnt_nxt   = wait_cnt;
    code_nxt  = halt_code;
    imem_req  = 1'b0;
    imem_addr = '0;
    rf_raddr  = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_wen    = 1'b0;
    retire    = 1'b0;
    halted    = 1'b0;
    case (state)
      S_FETCH: begin
        // rvalid here belongs to no request of ours and is ignored
        imem_req  = 1'b1;
        imem_addr = pc;
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        imem_addr = pc;
        cnt_nxt   = wait_cnt + 8'd1;
        // rvalid takes priority over a timeout landing on the same cycle
        if (imem_rvalid) begin
          ir_nxt    = imem_rdata;
          state_nxt = S_EXEC;
        end else if (wait_cnt == FETCH_TIMEOUT) begin
          code_nxt  = HC_TIMEOUT;
          state_nxt = S_HALT;
        end
      end
      S_EXEC: begin
        rf_raddr = ir[19:15];
        if (is_ebreak) begin
          code_nxt  = HC_EBREAK;
          state_nxt = S_HALT;
        end else if (is_addi) begin
          // rd==0 discards the result but the instruction still retires
          if (rd != 5'd0) begin
            rf_wen   = 1'b1;
            rf_waddr = rd;
            rf_wdata = addi_sum;
          end
          retire    = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_FETCH;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          code_nxt  = HC_ILLEGAL;
          state_nxt = S_HALT;
`else
          retire    = 1'b1;
          pc_nxt    = pc + 32'd4;
          state_nxt = S_FETCH;
`endif
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    // While reset is held the request port stays quiet even though state is FETCH
    if (!reset) begin
      imem_req  = 1'b0;
      imem_addr = '0;
    end
  end

endmodule
